// File: rtl/rd_fifo_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : rd_fifo_uart_tx
//  Description : Drains one BURST_LEN-word frame from the SDRAM read FIFO and
//                streams each 16-bit word to uart_tx as two bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_fifo_uart_tx #(
    parameter int unsigned BURST_LEN = 10,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [9:0]  rd_fifo_num,
    input  logic [15:0] rd_fifo_rd_data,
    output logic        rd_fifo_rd_req,
    output logic        read_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_flag,
    output logic        frame_done
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_POP   = 3'd1;
    localparam logic [2:0] c_LATCH = 3'd2;
    localparam logic [2:0] c_SEND0 = 3'd3;
    localparam logic [2:0] c_HOLD0 = 3'd4;
    localparam logic [2:0] c_SEND1 = 3'd5;
    localparam logic [2:0] c_HOLD1 = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    localparam logic [9:0] c_BURST_LEN = 10'(BURST_LEN);
    localparam logic [9:0] c_LAST_WORD = 10'(BURST_LEN - 1);

    logic [2:0]  r_state;
    logic [9:0]  r_word_cnt;
    logic [15:0] r_word_reg;
    logic        r_rd_req;
    logic        r_read_valid;
    logic [7:0]  r_tx_data;
    logic        r_tx_flag;
    logic        r_frame_done;

    logic [7:0]  w_first_byte;
    logic [7:0]  w_second_byte;

    // The first byte comes straight off the FIFO output, which stays stable
    // until the next pop; the second byte comes from the captured word.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_byte  = rd_fifo_rd_data[15:8];
            assign w_second_byte = r_word_reg[7:0];
        end else begin : g_lsb_first
            assign w_first_byte  = rd_fifo_rd_data[7:0];
            assign w_second_byte = r_word_reg[15:8];
        end
    endgenerate

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= c_IDLE;
            r_word_cnt   <= '0;
            r_word_reg   <= '0;
            r_rd_req     <= 1'b0;
            r_read_valid <= 1'b1;
            r_tx_data    <= '0;
            r_tx_flag    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_rd_req     <= 1'b0;
            r_tx_flag    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_read_valid <= 1'b1;
                    if (rd_fifo_num >= c_BURST_LEN) begin
                        r_read_valid <= 1'b0;
                        r_state      <= c_POP;
                    end
                end
                c_POP: begin
                    if (rd_fifo_num != 10'd0) begin
                        r_rd_req <= 1'b1;
                        r_state  <= c_LATCH;
                    end
                end
                // Pop is presented to the FIFO here; its data appears next cycle.
                c_LATCH: r_state <= c_SEND0;
                c_SEND0: begin
                    if (tx_ready) begin
                        r_tx_flag  <= 1'b1;
                        r_tx_data  <= w_first_byte;
                        r_word_reg <= rd_fifo_rd_data;
                        r_state    <= c_HOLD0;
                    end
                end
                c_HOLD0: r_state <= c_SEND1;
                c_SEND1: begin
                    if (tx_ready) begin
                        r_tx_flag <= 1'b1;
                        r_tx_data <= w_second_byte;
                        r_state   <= c_HOLD1;
                    end
                end
                c_HOLD1: begin
                    if (r_word_cnt == c_LAST_WORD) begin
                        r_word_cnt <= '0;
                        r_state    <= c_DONE;
                    end else begin
                        r_word_cnt <= r_word_cnt + 10'd1;
                        r_state    <= c_POP;
                    end
                end
                c_DONE: begin
                    r_frame_done <= 1'b1;
                    r_read_valid <= 1'b1;
                    r_state      <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign rd_fifo_rd_req = r_rd_req;
    assign read_valid     = r_read_valid;
    assign tx_data        = r_tx_data;
    assign tx_flag        = r_tx_flag;
    assign frame_done     = r_frame_done;

endmodule
`default_nettype wire
